// File: rtl/chopper_ctrl_n.sv
// chopper_ctrl_n: N-channel peak-current chopper controller.
// Each channel runs its own blank / on / fast-decay / slow-decay cycle. A
// short-circuit fault latches after FAULT_COUNT consecutive immediate
// comparator trips and is held until the global enable is dropped.
module chopper_ctrl_n #(
   parameter int CHANNELS    = 2,
   parameter int OFF_W       = 10,
   parameter int BLANK_W     = 8,
   parameter int MINON_W     = 8,
   parameter int FAULT_COUNT = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   input  logic [CHANNELS-1:0]   analog_cmp,
   input  logic [OFF_W-1:0]      config_offtime,
   input  logic [OFF_W-1:0]      config_fastdecay_time,
   input  logic [BLANK_W-1:0]    config_blanktime,
   input  logic [MINON_W-1:0]    config_minimum_on_time,
   output logic [CHANNELS-1:0]   drive_on,
   output logic [CHANNELS-1:0]   fast_decay,
   output logic [CHANNELS-1:0]   slow_decay,
   output logic [3*CHANNELS-1:0] state,
   output logic                  faultn
);

   localparam int FC_W = $clog2(FAULT_COUNT + 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FAULT_COUNT - 1);
   localparam logic [FC_W-1:0] FC_FULL = FC_W'(FAULT_COUNT);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BLANK = 3'd1,
      ST_ON    = 3'd2,
      ST_FAST  = 3'd3,
      ST_SLOW  = 3'd4,
      ST_FAULT = 3'd5
   } state_e;

   logic [BLANK_W-1:0]  b_eff;
   logic [MINON_W-1:0]  m_eff;
   logic [OFF_W-1:0]    t_eff;
   logic [OFF_W-1:0]    f_eff;
   logic [CHANNELS-1:0] fault_vec;

   // Effective durations: zero-length blank/min-on/off collapse to one cycle,
   // and the fast-decay share can never exceed the whole off period.
   always_comb begin
      b_eff = (config_blanktime == '0) ? BLANK_W'(1) : config_blanktime;
      m_eff = (config_minimum_on_time == '0) ? MINON_W'(1) : config_minimum_on_time;
      t_eff = (config_offtime == '0) ? OFF_W'(1) : config_offtime;
      f_eff = (config_fastdecay_time > t_eff) ? t_eff : config_fastdecay_time;
   end

   assign faultn = ~|fault_vec;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_e             st_q, st_d;
      logic [BLANK_W-1:0] blank_q, blank_d;
      logic [MINON_W-1:0] minon_q, minon_d;
      logic [OFF_W-1:0]   off_q, off_d;
      logic [OFF_W-1:0]   slow_len_q, slow_len_d;
      logic               elig_q, elig_d;
      logic [FC_W-1:0]    fcnt_q, fcnt_d;
      logic               drv_q, fast_q, slow_q, flt_q;

      // Next-state logic. elig_q marks that an eligible ON cycle with cmp=0
      // has already passed, so a later trip is a normal chop, not immediate.
      always_comb begin
         st_d       = st_q;
         blank_d    = blank_q;
         minon_d    = (minon_q != '0) ? minon_q - 1'b1 : '0;
         off_d      = off_q;
         slow_len_d = slow_len_q;
         elig_d     = elig_q;
         fcnt_d     = fcnt_q;
         case (st_q)
            ST_IDLE: begin
               if (enable) begin
                  st_d    = ST_BLANK;
                  blank_d = b_eff;
                  minon_d = m_eff;
                  elig_d  = 1'b0;
               end
            end
            ST_BLANK: begin
               if (blank_q <= BLANK_W'(1)) st_d = ST_ON;
               else                        blank_d = blank_q - 1'b1;
            end
            ST_ON: begin
               if (minon_q <= MINON_W'(1)) begin
                  if (analog_cmp[i]) begin
                     if (!elig_q && fcnt_q == FC_LAST) begin
                        st_d   = ST_FAULT;
                        fcnt_d = FC_FULL;
                     end else begin
                        fcnt_d     = elig_q ? '0 : fcnt_q + 1'b1;
                        st_d       = (f_eff != '0) ? ST_FAST : ST_SLOW;
                        off_d      = t_eff;
                        slow_len_d = t_eff - f_eff;
                     end
                  end else begin
                     elig_d = 1'b1;
                  end
               end
            end
            ST_FAST: begin
               if (off_q <= OFF_W'(1)) begin
                  st_d    = ST_BLANK;
                  blank_d = b_eff;
                  minon_d = m_eff;
                  elig_d  = 1'b0;
               end else begin
                  off_d = off_q - 1'b1;
                  if (off_q - 1'b1 == slow_len_q) st_d = ST_SLOW;
               end
            end
            ST_SLOW: begin
               if (off_q <= OFF_W'(1)) begin
                  st_d    = ST_BLANK;
                  blank_d = b_eff;
                  minon_d = m_eff;
                  elig_d  = 1'b0;
               end else begin
                  off_d = off_q - 1'b1;
               end
            end
            ST_FAULT: st_d = ST_FAULT;
            default:  st_d = ST_IDLE;
         endcase
         if (!enable) begin
            st_d   = ST_IDLE;
            fcnt_d = '0;
         end
      end

      // State, counters and bridge outputs, all registered from the next state.
      always_ff @(posedge clk) begin
         if (!resetn) begin
            st_q       <= ST_IDLE;
            blank_q    <= '0;
            minon_q    <= '0;
            off_q      <= '0;
            slow_len_q <= '0;
            elig_q     <= 1'b0;
            fcnt_q     <= '0;
            drv_q      <= 1'b0;
            fast_q     <= 1'b0;
            slow_q     <= 1'b0;
            flt_q      <= 1'b0;
         end else begin
            st_q       <= st_d;
            blank_q    <= blank_d;
            minon_q    <= minon_d;
            off_q      <= off_d;
            slow_len_q <= slow_len_d;
            elig_q     <= elig_d;
            fcnt_q     <= fcnt_d;
            drv_q      <= (st_d == ST_BLANK) || (st_d == ST_ON);
            fast_q     <= (st_d == ST_FAST);
            slow_q     <= (st_d == ST_SLOW);
            flt_q      <= (st_d == ST_FAULT);
         end
      end

      assign drive_on[i]      = drv_q;
      assign fast_decay[i]    = fast_q;
      assign slow_decay[i]    = slow_q;
      assign fault_vec[i]     = flt_q;
      assign state[3*i +: 3]  = st_q;
   end

endmodule

// File: doc/chopper_ctrl_n.md
# chopper_ctrl_n

Parametrised N-channel peak-current chopper controller for the microstepper datapath. It generalises the fixed two-bridge off/blank/minimum-on timer arrangement into a per-channel state machine with configurable channel count and timer widths. It adds two behaviours the fixed arrangement lacks: a mixed-decay off period (fast decay then slow decay) and a latched short-circuit fault on repeated immediate comparator trips. It sits between the analog current comparators and the bridge-phase decode logic.

## Interface
Parameters:
- CHANNELS, 2, number of independent bridges/comparators
- OFF_W, 10, width of off-time and fast-decay-time config
- BLANK_W, 8, width of blank-time config
- MINON_W, 8, width of minimum-on-time config
- FAULT_COUNT, 4, consecutive immediate trips that latch a fault (≥1)

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- enable  in  1  global drive enable
- analog_cmp  in  CHANNELS  per-channel comparator, 1 = current above threshold; already synchronised upstream
- config_offtime  in  OFF_W  total off period, cycles
- config_fastdecay_time  in  OFF_W  fast-decay portion of the off period, cycles
- config_blanktime  in  BLANK_W  comparator blanking after turn-on, cycles
- config_minimum_on_time  in  MINON_W  minimum on period from turn-on, cycles
- drive_on  out  CHANNELS  bridge driving forward current
- fast_decay  out  CHANNELS  bridge in fast (reverse) decay
- slow_decay  out  CHANNELS  bridge in slow (low-side recirculation) decay
- state  out  3*CHANNELS  per-channel state code, channel i at [3i+2:3i]
- faultn  out  1  0 while any channel is in FAULT

## Operation
- Each channel has an independent FSM. States and codes: IDLE=0, BLANK=1, ON=2, FAST=3, SLOW=4, FAULT=5. All outputs are registered and decoded from the state: drive_on in BLANK/ON, fast_decay in FAST, slow_decay in SLOW. faultn = no channel in FAULT.
- Effective durations: B = max(config_blanktime,1), M = max(config_minimum_on_time,1), T = max(config_offtime,1), F = min(config_fastdecay_time, T). Config is sampled when each state is entered; changes mid-state have no effect until the next entry.
- IDLE → BLANK when enable=1. On entry to BLANK, the blank counter loads B and the min-on counter loads M. Both decrement every cycle.
- BLANK: analog_cmp is ignored. After B cycles → ON.
- ON: exit is permitted once the min-on counter has expired, i.e. at least M cycles since BLANK entry. The first permitted cycle is the "eligible" cycle.
- In ON, if cmp=1 on an eligible or later cycle, the channel leaves ON. It goes to FAST if F>0, otherwise to SLOW, and the off counter loads T.
- FAST lasts F cycles, then SLOW for the remaining T−F cycles. If F=T, the channel goes FAST → BLANK directly. The total off period is always T cycles, after which the channel returns to BLANK.
- Fault counter, per channel, saturating at FAULT_COUNT:
  - Increments when cmp=1 on the eligible cycle (immediate trip).
  - Clears when the channel leaves ON with at least one cmp=0 eligible cycle.
  - When an immediate trip makes the count equal FAULT_COUNT, the next state is FAULT instead of FAST/SLOW.
- FAULT: all drive outputs are 0. The state is held regardless of cmp. It exits to IDLE only when enable=0, which also clears the fault counter.
- enable=0 in any state → IDLE on the next cycle, all drives 0, fault counter cleared. If enable is still 1 in IDLE, the channel re-enters BLANK.
- Channels never interact. Simultaneous trips on several channels are handled independently in the same cycle.

## Timing
- Reset (resetn=0 at an edge): every channel goes to IDLE with counters 0. Next cycle: drive_on=fast_decay=slow_decay=0, state=0, faultn=1. Reset overrides everything, including mid-off-period and FAULT.
- enable rises and is sampled at edge k → drive_on=1 and state=1 from edge k+1.
- BLANK is visible for exactly B cycles, then ON.
- A cmp=1 sampled at eligible edge e → fast_decay (or slow_decay) is visible from edge e+1. drive_on falls in the same cycle, so there is no overlap between drive and decay outputs.
- The off period is visible for exactly T cycles, then BLANK. The minimum chop period is B + (eligible wait) + T.
- A fault latched at edge e → faultn=0 from edge e+1.
- enable=0 sampled at edge k → all outputs 0 and faultn=1 at edge k+1.

## Test plan
- Reset mid-SLOW with enable=1 → next cycle state=0, all drives 0, faultn=1. The BLANK sequence then restarts.
- blank=5, min_on=3, off=20, fast=6, cmp rises 10 cycles after BLANK entry → drive_on for 10 cycles, fast_decay 6 cycles, slow_decay 14 cycles, drive_on again.
- blank=2, min_on=8, cmp held 1 → ON first permits exit 8 cycles after BLANK entry. That counts as an immediate trip.
- FAULT_COUNT=4, cmp stuck 1 → 3 full chop cycles, then FAULT on the 4th eligible cycle. faultn=0 until enable=0, then IDLE and faultn=1.
- offtime=0, fast=0, blanktime=0 → T=B=1. Sequence BLANK(1) → ON → SLOW(1) → BLANK.
- fast ≥ offtime (fast=30, off=12) → FAST for 12 cycles, SLOW never entered. Channel 1 is concurrently idle-tripping with no cross-effect.
